pwm_duty_decoder: RTL and testbench

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

---
 rtl/pwm_duty_decoder.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder
//
// Measures an incoming PWM waveform and reports its duty cycle in tenths
// (0..10), along with the raw period and high time in clock cycles.
//
// A measurement spans rising edge to rising edge. At each rising edge (while
// measuring) the period/high-time counters are snapshotted into a small
// sequential divider that computes floor(10*high/period), one quotient bit per
// clock. If the divider is still busy when the next rising edge arrives, that
// snapshot is dropped and the sticky overrun flag is raised.
//
// If the input shows no edge for TIMEOUT clocks the block declares the signal
// stuck. It reports 0% or 100% according to the static level and zeroes
// period/high_time. It pulses valid once, aborts any running division and
// re-arms. The next rising edge clears stuck.
//
// Parameters
//   CNT_W    width of the period and high-time counters (saturating)
//   TIMEOUT  clocks without any pwm_in edge before stuck is declared
//
// Ports
//   clk        in   single clock, all state on rising edge
//   rst_n      in   asynchronous assert, active-low reset
//   pwm_in     in   PWM input, asynchronous to clk
//   clr_ovr    in   synchronous clear of the overrun flag
//   duty       out  duty cycle in tenths, 0..10
//   period     out  last measured period in clocks (0 only while stuck)
//   high_time  out  last measured high time in clocks
//   valid      out  one-cycle pulse when duty/period/high_time update
//   busy       out  divider running
//   overrun    out  sticky: a measurement was dropped
//   stuck      out  pwm_in has been static for TIMEOUT clocks
// -----------------------------------------------------------------------------
module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             clr_ovr,
    output logic [3:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             stuck
);

    // The dividend is 10*high, which needs 4 more bits than the counters.
    localparam int DIV_W = CNT_W + 4;

    // The idle counter is sized from TIMEOUT alone. This lets a narrow
    // measurement counter coexist with a long stuck timeout.
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [3:0]        DUTY_FULL  = 4'd10;

    typedef enum logic {
        ARMED = 1'b0,
        MEAS  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer plus one history stage for edge detection
    // -------------------------------------------------------------------------
    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= pwm_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    logic rise;
    logic fall;

    assign rise = s2_reg & ~s3_reg;
    assign fall = ~s2_reg & s3_reg;

    // -------------------------------------------------------------------------
    // Idle (stuck) detection
    // -------------------------------------------------------------------------
    logic [IDLE_W-1:0] idle_reg;
    logic [IDLE_W-1:0] idle_next;
    logic              stuck_event;

    always_comb begin
        idle_next = idle_reg;
        if (rise || fall) begin
            idle_next = '0;
        end else if (idle_reg != IDLE_LIMIT) begin
            idle_next = idle_reg + IDLE_ONE;
        end
    end

    // Fires only on the edge where the counter first reaches the limit.
    // The counter then parks there, so the stuck report is not repeated
    // until an input edge restarts the count.
    assign stuck_event = (idle_next == IDLE_LIMIT) && (idle_reg != IDLE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_next;
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM: state register / next-state logic / output decode
    // -------------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;

    logic cnt_load;   // reload both counters to 1 (a rising edge was seen)
    logic cnt_run;    // advance counters for one more clock of this period
    logic snap_req;   // a full period just completed; offer it to the divider

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARMED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stuck_event) begin
            state_next = ARMED;
        end else begin
            case (state_reg)
                ARMED:   if (rise) state_next = MEAS;
                MEAS:    state_next = MEAS;
                default: state_next = ARMED;
            endcase
        end
    end

    // The first rise after arming only starts the counters. There is no
    // complete period behind it yet, so it takes no snapshot.
    always_comb begin
        cnt_load = 1'b0;
        cnt_run  = 1'b0;
        snap_req = 1'b0;
        if (!stuck_event) begin
            case (state_reg)
                ARMED: begin
                    cnt_load = rise;
                end
                MEAS: begin
                    if (rise) begin
                        cnt_load = 1'b1;
                        snap_req = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                    end
                end
                default: begin
                    cnt_load = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Period / high-time counters (saturating)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] period_cnt_reg;
    logic [CNT_W-1:0] period_cnt_next;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] high_cnt_next;

    // Both counters start at 1 on the same edge and both saturate at the
    // same ceiling. Therefore high_cnt never exceeds period_cnt, and the
    // quotient can never exceed 10.
    always_comb begin
        period_cnt_next = period_cnt_reg;
        high_cnt_next   = high_cnt_reg;
        if (cnt_load) begin
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
        end else if (cnt_run) begin
            if (period_cnt_reg != CNT_MAX) begin
                period_cnt_next = period_cnt_reg + CNT_ONE;
            end
            if (s2_reg && (high_cnt_reg != CNT_MAX)) begin
                high_cnt_next = high_cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
        end else begin
            period_cnt_reg <= period_cnt_next;
            high_cnt_reg   <= high_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Divider: floor(10*high / period), restoring, 4 quotient bits MSB first
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] rem_reg;        // running remainder
    logic [CNT_W-1:0] div_reg;        // divisor (snapshotted period)
    logic [3:0]       quot_reg;       // quotient bits resolved so far
    logic [1:0]       step_reg;       // weight of the quotient bit being resolved
    logic             busy_reg;
    logic [CNT_W-1:0] snap_period_reg;
    logic [CNT_W-1:0] snap_high_reg;

    logic [DIV_W-1:0] times_ten;
    logic [DIV_W-1:0] div_shift;
    logic             trial_fits;
    logic [DIV_W-1:0] rem_step;
    logic [3:0]       quot_step;
    logic             snap_accept;
    logic             ovr_event;

    // 10*h = 8*h + 2*h. This avoids a generic multiplier.
    assign times_ten = (DIV_W'(high_cnt_reg) << 3) + (DIV_W'(high_cnt_reg) << 1);

    // Because high <= period, the dividend is below 16*period.
    // Four trial subtractions at weights 8,4,2,1 therefore cover the
    // entire quotient.
    always_comb begin
        div_shift            = DIV_W'(div_reg) << step_reg;
        trial_fits           = (rem_reg >= div_shift);
        rem_step             = trial_fits ? (rem_reg - div_shift) : rem_reg;
        quot_step            = quot_reg;
        quot_step[step_reg]  = trial_fits;
    end

    assign snap_accept = snap_req & ~busy_reg;
    assign ovr_event   = snap_req &  busy_reg;

    // -------------------------------------------------------------------------
    // Result registers
    // -------------------------------------------------------------------------
    logic [3:0]       duty_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_time_reg;
    logic             valid_reg;
    logic             stuck_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg         <= '0;
            div_reg         <= '0;
            quot_reg        <= '0;
            step_reg        <= '0;
            busy_reg        <= 1'b0;
            snap_period_reg <= '0;
            snap_high_reg   <= '0;
            duty_reg        <= '0;
            period_reg      <= '0;
            high_time_reg   <= '0;
            valid_reg       <= 1'b0;
            stuck_reg       <= 1'b0;
        end else if (stuck_event) begin
            // Stuck overrides everything. Any division in flight is
            // abandoned and must not deliver its result afterwards.
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b1;
            stuck_reg     <= 1'b1;
            duty_reg      <= s2_reg ? DUTY_FULL : 4'd0;
            period_reg    <= '0;
            high_time_reg <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (rise) begin
                stuck_reg <= 1'b0;
            end

            if (snap_accept) begin
                rem_reg         <= times_ten;
                div_reg         <= period_cnt_reg;
                snap_period_reg <= period_cnt_reg;
                snap_high_reg   <= high_cnt_reg;
                quot_reg        <= '0;
                step_reg        <= 2'd3;
                busy_reg        <= 1'b1;
            end else if (busy_reg) begin
                rem_reg  <= rem_step;
                quot_reg <= quot_step;
                step_reg <= step_reg - 2'd1;
                if (step_reg == 2'd0) begin
                    // The last bit has just resolved. Publish all three
                    // results together, so a consumer sampling on valid
                    // sees a consistent set.
                    busy_reg      <= 1'b0;
                    valid_reg     <= 1'b1;
                    duty_reg      <= quot_step;
                    period_reg    <= snap_period_reg;
                    high_time_reg <= snap_high_reg;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overrun: a dropped snapshot beats a clear in the same cycle
    // -------------------------------------------------------------------------
    logic overrun_reg;
    logic overrun_next;

    always_comb begin
        overrun_next = overrun_reg;
        if (ovr_event) begin
            overrun_next = 1'b1;
        end else if (clr_ovr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= overrun_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign duty      = duty_reg;
    assign period    = period_reg;
    assign high_time = high_time_reg;
    assign valid     = valid_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;
    assign stuck     = stuck_reg;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
`timescale 1ns/1ps
module tb_pwm_duty_decoder;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic             rst_n;
    logic             pwm_in;
    logic             clr_ovr;
    logic [3:0]       duty;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             busy;
    logic             overrun;
    logic             stuck;

    // narrow-counter instance for saturation
    logic             pwm_sat;
    logic [3:0]       duty_s;
    logic [3:0]       period_s;
    logic [3:0]       high_s;
    logic             valid_s;
    logic             busy_s;
    logic             ovr_s;
    logic             stuck_s;

    pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .clr_ovr   (clr_ovr),
        .duty      (duty),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun),
        .stuck     (stuck)
    );

    pwm_duty_decoder #(.CNT_W(4), .TIMEOUT(TIMEOUT)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_sat),
        .clr_ovr   (clr_ovr),
        .duty      (duty_s),
        .period    (period_s),
        .high_time (high_s),
        .valid     (valid_s),
        .busy      (busy_s),
        .overrun   (ovr_s),
        .stuck     (stuck_s)
    );

    typedef struct packed {
        logic [3:0]       duty;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic             stk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    int prev_h    = 0;
    int prev_p    = 0;
    bit have_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int d, input int p, input int h, input logic s);
        exp_t e;
        e.duty = 4'(d);
        e.per  = CNT_W'(p);
        e.hi   = CNT_W'(h);
        e.stk  = s;
        sb.push_back(e);
    endtask

    task automatic pwm_period(input int h, input int l);
        pwm_in = 1'b1;
        tick(h);
        pwm_in = 1'b0;
        tick(l);
    endtask

    // Each rise in MEAS closes the previous period; expect its result.
    task automatic meas_period(input int h, input int l);
        if (have_prev) push_exp((10 * prev_h) / prev_p, prev_p, prev_h, 1'b0);
        pwm_period(h, l);
        prev_h    = h;
        prev_p    = h + l;
        have_prev = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // Result monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("duty",      32'(duty),      32'(mon_e.duty));
                check("period",    32'(period),    32'(mon_e.per));
                check("high_time", 32'(high_time), 32'(mon_e.hi));
                check("stuck",     32'(stuck),     32'(mon_e.stk));
                $display("txn: duty=%0d period=%0d high_time=%0d stuck=%0d", duty, period, high_time, stuck);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bc;

        rst_n   = 1'b0;
        pwm_in  = 1'b0;
        clr_ovr = 1'b0;
        pwm_sat = 1'b0;
        tick(3);

        // reset values
        check("rst_duty",      32'(duty),      32'd0);
        check("rst_period",    32'(period),    32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_stuck",     32'(stuck),     32'd0);
        rst_n = 1'b1;
        tick(2);

        // saturation on the 4-bit instance: high 20 / period 30
        repeat (2) begin
            pwm_sat = 1'b1;
            tick(20);
            pwm_sat = 1'b0;
            tick(10);
        end
        pwm_sat = 1'b1;
        n = 0;
        while (valid_s !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("sat_valid_seen", 32'(valid_s),  32'd1);
        check("sat_duty",       32'(duty_s),   32'd10);
        check("sat_period",     32'(period_s), 32'd15);
        check("sat_high",       32'(high_s),   32'd15);
        pwm_sat = 1'b0;

        // 50% at period 10
        have_prev = 1'b0;
        repeat (6) meas_period(5, 5);

        // 90%, 10%, and 3/7 (floor to 4)
        meas_period(9, 1);
        meas_period(1, 9);
        meas_period(3, 4);
        meas_period(3, 4);

        // busy lasts exactly 4 cycles per accepted snapshot
        push_exp((10 * prev_h) / prev_p, prev_p, prev_h, 1'b0);
        pwm_in = 1'b1;
        bc = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) pwm_in = 1'b0;
            tick(1);
            if (busy === 1'b1) bc++;
        end
        check("busy_cycles", 32'(bc), 32'd4);
        prev_h = 5;
        prev_p = 10;

        // held high -> stuck at 100%
        push_exp(5, 10, 5, 1'b0);
        push_exp(10, 0, 0, 1'b1);
        have_prev = 1'b0;
        pwm_in = 1'b1;
        tick(1010);
        check("stuck_hi",        32'(stuck),  32'd1);
        check("stuck_hi_duty",   32'(duty),   32'd10);
        check("stuck_hi_period", 32'(period), 32'd0);
        tick(50);
        check("stuck_single_valid", 32'(sb.size()), 32'd0);
        pwm_in = 1'b0;
        tick(5);
        check("stuck_kept_on_fall", 32'(stuck), 32'd1);
        pwm_in = 1'b1;
        tick(5);
        check("stuck_cleared_by_rise", 32'(stuck), 32'd0);

        // held low -> stuck at 0%
        pwm_in = 1'b0;
        push_exp(0, 0, 0, 1'b1);
        tick(1010);
        check("stuck_lo",      32'(stuck), 32'd1);
        check("stuck_lo_duty", 32'(duty),  32'd0);
        check("ovr_before",    32'(overrun), 32'd0);

        // period 3: every other snapshot lands while busy
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) push_exp(6, 3, 2, 1'b0);
            pwm_in = 1'b1;
            tick(2);
            pwm_in = 1'b0;
            tick(1);
        end
        check("overrun_set", 32'(overrun), 32'd1);
        wait_drain(30);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);

        // reset in the middle of a division
        pwm_in = 1'b1;
        tick(4);
        check("busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        sb.delete();
        #1;
        check("async_rst_busy",   32'(busy),      32'd0);
        check("async_rst_valid",  32'(valid),     32'd0);
        check("async_rst_duty",   32'(duty),      32'd0);
        check("async_rst_period", 32'(period),    32'd0);
        check("async_rst_high",   32'(high_time), 32'd0);
        check("async_rst_stuck",  32'(stuck),     32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // after release, first rise only arms
        have_prev = 1'b0;
        meas_period(5, 5);
        meas_period(3, 7);
        meas_period(5, 5);
        wait_drain(30);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
